// File: rtl/multi_digit_counter_pkg.sv
// Shared constants for the multi-digit counter: seven-segment glyphs and
// the legal parameter ranges.
package multi_digit_counter_pkg;

    // Active-low {g,f,e,d,c,b,a} glyphs for nibble values 0..F.
    localparam logic [6:0] GLYPHS [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic bit params_ok(input int digits, input int radix,
                                     input int wrap, input int db_cycles);
        return (digits >= 1) && (digits <= 8) &&
               ((radix == 10) || (radix == 16)) &&
               ((wrap == 0) || (wrap == 1)) &&
               (db_cycles >= 1) && (db_cycles <= 65535);
    endfunction

endpackage

// File: rtl/multi_digit_counter_button_conditioner.sv
// One active-low push button: 2-flop synchroniser, stability debounce and
// a single-cycle pulse on each accepted press (debounced 1->0).
module button_conditioner
    import multi_digit_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic butt_n_i,
    output logic press_o
);

    localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync1_q, sync2_q;
    logic        db_q, db_d;
    logic [15:0] cnt_q, cnt_d;
    logic        press_q;

    // Any cycle where the synchronised level matches the debounced one
    // restarts the stability count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == LAST) db_d  = sync2_q;
            else               cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= butt_n_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= db_q & ~db_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/multi_digit_counter.sv
// Up/down multi-digit BCD or hex counter driven by two debounced buttons,
// with registered seven-segment outputs.
module multi_digit_counter
    import multi_digit_counter_pkg::*;
#(
    parameter int DIGITS          = 2,
    parameter int RADIX           = 10,
    parameter int WRAP            = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  butt_add,
    input  logic                  butt_sub,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   sevenseg,
    output logic                  at_zero,
    output logic                  at_max
);

    if (!params_ok(DIGITS, RADIX, WRAP, DEBOUNCE_CYCLES)) begin : g_bad_params
        $error("multi_digit_counter: illegal DIGITS/RADIX/WRAP/DEBOUNCE_CYCLES");
    end

    localparam logic [3:0] TOP = 4'(RADIX - 1);

    logic                   add_p, sub_p;
    logic [DIGITS-1:0][3:0] count_q, count_d, inc_v, dec_v;
    logic [DIGITS-1:0][6:0] seg_q;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add (
        .clock(clock), .reset(reset), .butt_n_i(butt_add), .press_o(add_p)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sub (
        .clock(clock), .reset(reset), .butt_n_i(butt_sub), .press_o(sub_p)
    );

    // Ripple carry/borrow across digits; a full ripple naturally wraps.
    always_comb begin
        logic carry, borrow;
        inc_v  = count_q;
        dec_v  = count_q;
        carry  = 1'b1;
        borrow = 1'b1;
        at_max = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count_q[i] != TOP) at_max = 1'b0;
            if (carry) begin
                if (count_q[i] == TOP) inc_v[i] = 4'd0;
                else begin
                    inc_v[i] = count_q[i] + 4'd1;
                    carry    = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[i] == 4'd0) dec_v[i] = TOP;
                else begin
                    dec_v[i] = count_q[i] - 4'd1;
                    borrow   = 1'b0;
                end
            end
        end
    end

    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (add_p && !sub_p && ((WRAP != 0) || !at_max))
            count_d = inc_v;
        else if (sub_p && !add_p && ((WRAP != 0) || !at_zero))
            count_d = dec_v;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < DIGITS; i++) seg_q[i] <= GLYPHS[0];
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DIGITS; i++) seg_q[i] <= GLYPHS[count_q[i]];
        end
    end

    assign count    = count_q;
    assign sevenseg = seg_q;

endmodule

// File: tb/tb_multi_digit_counter.sv
// Directed bench: three counters (BCD saturate, BCD wrap, hex wrap) with
// DEBOUNCE_CYCLES=4, each driven by its own buttons and reset.
module tb_multi_digit_counter;

    logic       clk = 1'b0;
    logic [2:0] rst_n = 3'b000;
    logic [2:0] add_n = 3'b111;
    logic [2:0] sub_n = 3'b111;

    logic [7:0]  cnt0, cnt1, cnt2;
    logic [13:0] seg0, seg1, seg2;
    logic        az0, az1, az2, am0, am1, am2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_digit_counter #(.DIGITS(2), .RADIX(10), .WRAP(0), .DEBOUNCE_CYCLES(4)) u0 (
        .clock(clk), .reset(rst_n[0]), .butt_add(add_n[0]), .butt_sub(sub_n[0]),
        .count(cnt0), .sevenseg(seg0), .at_zero(az0), .at_max(am0));
    multi_digit_counter #(.DIGITS(2), .RADIX(10), .WRAP(1), .DEBOUNCE_CYCLES(4)) u1 (
        .clock(clk), .reset(rst_n[1]), .butt_add(add_n[1]), .butt_sub(sub_n[1]),
        .count(cnt1), .sevenseg(seg1), .at_zero(az1), .at_max(am1));
    multi_digit_counter #(.DIGITS(2), .RADIX(16), .WRAP(1), .DEBOUNCE_CYCLES(4)) u2 (
        .clock(clk), .reset(rst_n[2]), .butt_add(add_n[2]), .butt_sub(sub_n[2]),
        .count(cnt2), .sevenseg(seg2), .at_zero(az2), .at_max(am2));

    // Hold one button low for 'low' sampled cycles, then let it settle.
    task automatic press(input int d, input bit is_add, input int low);
        @(negedge clk);
        if (is_add) add_n[d] = 1'b0;
        else        sub_n[d] = 1'b0;
        repeat (low) @(negedge clk);
        add_n[d] = 1'b1;
        sub_n[d] = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (cnt0 !== 8'h00) begin errors++; $display("FAIL reset_count got %h want 00", cnt0); end
        checks++;
        if (seg0 !== 14'b1000000_1000000) begin errors++; $display("FAIL reset_seg got %b want 10000001000000", seg0); end
        checks++;
        if ({az0, am0} !== 2'b10) begin errors++; $display("FAIL reset_flags got %b want 10", {az0, am0}); end
        rst_n = 3'b111;
    endtask

    task automatic test_add_count;
        for (int i = 0; i < 12; i++) press(0, 1'b1, 6);
        checks++;
        if (cnt0 !== 8'h12) begin errors++; $display("FAIL add12_count got %h want 12", cnt0); end
        checks++;
        if (seg0 !== 14'b1111001_0100100) begin errors++; $display("FAIL add12_seg got %b want 11110010100100", seg0); end
        checks++;
        if ({az0, am0} !== 2'b00) begin errors++; $display("FAIL add12_flags got %b want 00", {az0, am0}); end
    endtask

    task automatic test_debounce;
        press(0, 1'b1, 3);
        checks++;
        if (cnt0 !== 8'h12) begin errors++; $display("FAIL bounce3 got %h want 12", cnt0); end
        press(0, 1'b1, 4);
        checks++;
        if (cnt0 !== 8'h13) begin errors++; $display("FAIL hold4 got %h want 13", cnt0); end
        press(0, 1'b1, 20);
        checks++;
        if (cnt0 !== 8'h14) begin errors++; $display("FAIL hold20 got %h want 14", cnt0); end
    endtask

    task automatic test_both;
        @(negedge clk);
        add_n[0] = 1'b0;
        sub_n[0] = 1'b0;
        repeat (6) @(negedge clk);
        add_n[0] = 1'b1;
        sub_n[0] = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (cnt0 !== 8'h14) begin errors++; $display("FAIL both_hold got %h want 14", cnt0); end
    endtask

    task automatic test_sub_borrow;
        for (int i = 0; i < 5; i++) press(0, 1'b0, 6);
        checks++;
        if (cnt0 !== 8'h09) begin errors++; $display("FAIL borrow got %h want 09", cnt0); end
        checks++;
        if (seg0 !== 14'b1000000_0010000) begin errors++; $display("FAIL borrow_seg got %b want 10000000010000", seg0); end
    endtask

    task automatic test_saturate;
        @(negedge clk); rst_n[0] = 1'b0;
        repeat (2) @(negedge clk); rst_n[0] = 1'b1;
        press(0, 1'b0, 6);
        checks++;
        if ({cnt0, az0} !== {8'h00, 1'b1}) begin errors++; $display("FAIL sat_sub0 got %h/%b want 00/1", cnt0, az0); end
        for (int i = 0; i < 99; i++) press(0, 1'b1, 5);
        checks++;
        if ({cnt0, am0} !== {8'h99, 1'b1}) begin errors++; $display("FAIL reach99 got %h/%b want 99/1", cnt0, am0); end
        checks++;
        if (seg0 !== 14'b0010000_0010000) begin errors++; $display("FAIL seg99 got %b want 00100000010000", seg0); end
        press(0, 1'b1, 6);
        checks++;
        if ({cnt0, am0} !== {8'h99, 1'b1}) begin errors++; $display("FAIL sat_add99 got %h/%b want 99/1", cnt0, am0); end
    endtask

    task automatic test_wrap_dec;
        press(1, 1'b0, 6);
        checks++;
        if ({cnt1, am1, az1} !== {8'h99, 2'b10}) begin errors++; $display("FAIL wrap_sub0 got %h/%b%b want 99/10", cnt1, am1, az1); end
        press(1, 1'b1, 6);
        checks++;
        if ({cnt1, az1} !== {8'h00, 1'b1}) begin errors++; $display("FAIL wrap_add99 got %h/%b want 00/1", cnt1, az1); end
    endtask

    task automatic test_hex_wrap;
        press(2, 1'b0, 6);
        checks++;
        if ({cnt2, am2} !== {8'hFF, 1'b1}) begin errors++; $display("FAIL hex_sub0 got %h/%b want ff/1", cnt2, am2); end
        press(2, 1'b1, 6);
        checks++;
        if (cnt2 !== 8'h00) begin errors++; $display("FAIL hex_addff got %h want 00", cnt2); end
        for (int i = 0; i < 16; i++) press(2, 1'b1, 5);
        checks++;
        if (cnt2 !== 8'h10) begin errors++; $display("FAIL hex_add16 got %h want 10", cnt2); end
        press(2, 1'b0, 6);
        checks++;
        if (cnt2 !== 8'h0F) begin errors++; $display("FAIL hex_sub10 got %h want 0f", cnt2); end
        checks++;
        if (seg2 !== 14'b1000000_0001110) begin errors++; $display("FAIL hex_seg0f got %b want 10000000001110", seg2); end
    endtask

    // Press runs 5 cycles (one short of a pulse), reset lands, and the
    // button stays low one cycle past reset release.
    task automatic test_reset_mid;
        @(negedge clk); add_n[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst_n[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk); add_n[0] = 1'b1;
        repeat (15) @(negedge clk);
        checks++;
        if ({cnt0, az0} !== {8'h00, 1'b1}) begin errors++; $display("FAIL reset_mid got %h/%b want 00/1", cnt0, az0); end
    endtask

    initial begin
        test_reset;
        test_add_count;
        test_debounce;
        test_both;
        test_sub_borrow;
        test_saturate;
        test_wrap_dec;
        test_hex_wrap;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
